mode_counter: RTL and testbench
===============================

// Module: mode_counter
// PURPOSE
//  Parametrised up/down counter with free-run and manual-step modes, driven by raw push-buttons.
//  Buttons are active-low: add_n, minus_n, pause_n. Each is synchronised and falling-edge detected
//  into a one-cycle press pulse. Adds modulus, wrap/saturate select, prescaled run rate, direction
//  control, parallel load and terminal-count pulse. Sits between board buttons and display/decoder logic.
// PARAMETERS
//  N           8          counter width in bits
//  MAX         2**N-1     top count; range is 0..MAX; legal values 1 <= MAX <= 2**N-1
//  PRESCALE    1          in RUN, one step every PRESCALE clocks; must be >= 1
//  SYNC_STAGES 2          synchroniser depth per button; must be >= 2
//  SATURATE    0          0: wrap at the ends; 1: clamp at 0 and MAX
// PORTS
//  clk      in   1  single clock, rising edge
//  reset    in   1  asynchronous, active-low reset (asserted when 0)
//  add_n    in   1  button, active-low, asynchronous
//  minus_n  in   1  button, active-low, asynchronous
//  pause_n  in   1  button, active-low, asynchronous; each press toggles RUN/HOLD
//  load     in   1  synchronous parallel load strobe, active-high
//  d        in   N  load value
//  q        out  N  count value
//  running  out  1  1 = RUN state, 0 = HOLD state
//  dir_up   out  1  RUN direction: 1 = up, 0 = down
//  tc       out  1  one-cycle pulse on each wrap (MAX->0 or 0->MAX)
// BEHAVIOUR
//  Reset (reset=0, acts immediately, asynchronous):
//   q=0, running=1, dir_up=1, tc=0, prescaler=0, all sync flops=1 (released).
//  Press detection: SYNC_STAGES-flop synchroniser, then falling-edge detect against a delayed copy.
//   Latency: a low level first sampled at edge 1 updates state or q at edge SYNC_STAGES+1.
//   One press per falling edge, regardless of hold time.
//   A button held low across reset release counts as exactly one press.
//  FSM states: RUN (running=1) and HOLD (running=0). A pause press toggles the state.
//   On the cycle of a pause press, add/minus presses are ignored.
//   Prescaler is cleared on every state change.
//  RUN:
//   Prescaler counts 0..PRESCALE-1 every clock; a step occurs in the cycle it equals PRESCALE-1.
//   Step direction follows dir_up.
//   add press sets dir_up=1; minus press sets dir_up=0; both in the same cycle leave dir_up unchanged.
//   add/minus presses never step q directly while in RUN.
//  HOLD:
//   Prescaler is held at 0.
//   add press steps q +1; minus press steps q -1; both in the same cycle: no change. dir_up unchanged.
//  Priority, per cycle: reset > load > pause press > step.
//   load: q <= (d > MAX) ? MAX : d; prescaler cleared; state and dir_up unchanged; no tc;
//   all presses in that cycle are discarded.
//  Step arithmetic: q never exceeds MAX.
//   Up from MAX: SATURATE=0 gives q=0 and tc=1; SATURATE=1 holds q=MAX, tc=0.
//   Down from 0: SATURATE=0 gives q=MAX and tc=1; SATURATE=1 holds q=0, tc=0.
//   Otherwise q +/- 1 with tc=0.
//  tc is registered: high for exactly the cycle after the wrapping edge.
//  All outputs are registered; no combinational path from inputs to outputs.
// TESTING
//  1 N=8, MAX=9, PRESCALE=4; release reset -> q steps 0,1,..,9 once every 4 clocks; q 9->0 with tc high 1 cycle.
//  2 Pulse pause_n low 3 clocks -> running=0 exactly SYNC_STAGES+1 edges after first sample; q frozen;
//    3 add presses -> q+3; at q=0, minus press -> q=9, tc pulse.
//  3 SATURATE=1, MAX=9, HOLD: q=9 + add press -> q=9, tc=0; q=0 + minus press -> q=0, tc=0.
//  4 HOLD, q=4: add+minus pressed together -> q=4; pause+add together -> running=1, q=4, dir_up unchanged.
//  5 load with d=200, MAX=9 -> q=9; in RUN, load d=5 -> q=5, next step to 6 after exactly PRESCALE clocks.
//  6 RUN, q=7: drop reset between edges -> q=0 and running=1 before the next edge;
//    add_n held low across release -> exactly one press.

Source files
------------

// File: rtl/mode_counter.sv
// Up/down counter driven by raw active-low push-buttons, with free-run (RUN) and
// manual-step (HOLD) modes, prescaled run rate, parallel load and terminal-count pulse.
module mode_counter #(
    parameter int N           = 8,
    parameter int MAX         = 2**N - 1,
    parameter int PRESCALE    = 1,
    parameter int SYNC_STAGES = 2,
    parameter bit SATURATE    = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         add_n,
    input  logic         minus_n,
    input  logic         pause_n,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         running,
    output logic         dir_up,
    output logic         tc
);

    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [N-1:0]    MAX_Q   = N'(MAX);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    typedef enum logic {S_HOLD = 1'b0, S_RUN = 1'b1} state_t;

    // Button lanes: bit 0 = add, bit 1 = minus, bit 2 = pause.
    logic [2:0]             btn_raw;
    logic [SYNC_STAGES-1:0] sync_r [3];
    logic [2:0]             dly_r;
    logic [2:0]             press;
    logic                   add_press;
    logic                   minus_press;
    logic                   pause_press;

    state_t          state_r, state_nxt;
    logic [N-1:0]    q_nxt;
    logic            dir_nxt;
    logic            tc_nxt;
    logic [PS_W-1:0] presc_r, presc_nxt;
    logic            step_up;
    logic            step_dn;

    assign btn_raw = {pause_n, minus_n, add_n};

    // Flops reset to the released level, so a button held through reset yields one press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                sync_r[i] <= '1;
            end
            dly_r <= '1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                sync_r[i] <= {sync_r[i][SYNC_STAGES-2:0], btn_raw[i]};
                dly_r[i]  <= sync_r[i][SYNC_STAGES-1];
            end
        end
    end

    always_comb begin
        press = '0;
        for (int i = 0; i < 3; i++) begin
            press[i] = dly_r[i] & ~sync_r[i][SYNC_STAGES-1];
        end
    end

    assign add_press   = press[0];
    assign minus_press = press[1];
    assign pause_press = press[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_RUN;
            q       <= '0;
            dir_up  <= 1'b1;
            tc      <= 1'b0;
            presc_r <= '0;
        end else begin
            state_r <= state_nxt;
            q       <= q_nxt;
            dir_up  <= dir_nxt;
            tc      <= tc_nxt;
            presc_r <= presc_nxt;
        end
    end

    assign running = (state_r == S_RUN);

    always_comb begin
        state_nxt = state_r;
        q_nxt     = q;
        dir_nxt   = dir_up;
        tc_nxt    = 1'b0;
        presc_nxt = presc_r;
        step_up   = 1'b0;
        step_dn   = 1'b0;

        if (load) begin
            q_nxt     = (d > MAX_Q) ? MAX_Q : d;
            presc_nxt = '0;
        end else if (pause_press) begin
            state_nxt = (state_r == S_RUN) ? S_HOLD : S_RUN;
            presc_nxt = '0;
        end else if (state_r == S_RUN) begin
            if (add_press && !minus_press) begin
                dir_nxt = 1'b1;
            end else if (minus_press && !add_press) begin
                dir_nxt = 1'b0;
            end
            // Step direction uses the direction held before this cycle's presses.
            if (presc_r == PS_LAST) begin
                presc_nxt = '0;
                step_up   = dir_up;
                step_dn   = ~dir_up;
            end else begin
                presc_nxt = presc_r + PS_W'(1);
            end
        end else begin
            presc_nxt = '0;
            step_up   = add_press & ~minus_press;
            step_dn   = minus_press & ~add_press;
        end

        if (step_up) begin
            if (q >= MAX_Q) begin
                if (SATURATE) begin
                    q_nxt = MAX_Q;
                end else begin
                    q_nxt  = '0;
                    tc_nxt = 1'b1;
                end
            end else begin
                q_nxt = q + N'(1);
            end
        end else if (step_dn) begin
            if (q == '0) begin
                if (SATURATE) begin
                    q_nxt = '0;
                end else begin
                    q_nxt  = MAX_Q;
                    tc_nxt = 1'b1;
                end
            end else begin
                q_nxt = q - N'(1);
            end
        end
    end

endmodule

// File: tb/tb_mode_counter.sv
// Bench for mode_counter: a wrapping instance and a saturating instance, directed
// button/load sequences, and a cycle-stamped expected queue checked by a monitor.
module tb_mode_counter;

    localparam int N = 8;

    typedef struct packed {
        int          cyc;
        logic        dut;
        logic [10:0] val;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         add_n_m, minus_n_m, pause_n_m, load_m;
    logic         add_n_s, minus_n_s, pause_n_s, load_s;
    logic [N-1:0] d_m, d_s;
    logic [N-1:0] q_m, q_s;
    logic         running_m, dir_up_m, tc_m;
    logic         running_s, dir_up_s, tc_s;

    int   cyc;
    int   n_checks;
    int   n_fail;
    int   mon_i;
    exp_t exp_q[$];

    mode_counter #(.N(N), .MAX(9), .PRESCALE(4), .SYNC_STAGES(2), .SATURATE(1'b0)) dut_m (
        .clk(clk), .reset(reset), .add_n(add_n_m), .minus_n(minus_n_m), .pause_n(pause_n_m),
        .load(load_m), .d(d_m), .q(q_m), .running(running_m), .dir_up(dir_up_m), .tc(tc_m)
    );

    mode_counter #(.N(N), .MAX(9), .PRESCALE(4), .SYNC_STAGES(2), .SATURATE(1'b1)) dut_s (
        .clk(clk), .reset(reset), .add_n(add_n_s), .minus_n(minus_n_s), .pause_n(pause_n_s),
        .load(load_s), .d(d_s), .q(q_s), .running(running_s), .dir_up(dir_up_s), .tc(tc_s)
    );

    // Clock and cycle stamp
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic dut, input int dly, input int qv,
                            input logic r, input logic dv, input logic tv);
        exp_t e;
        e.cyc = cyc + dly;
        e.dut = dut;
        e.val = {N'(qv), r, dv, tv};
        exp_q.push_back(e);
    endtask

    task automatic expect_m(input int dly, input int qv, input logic r, input logic dv, input logic tv);
        push_exp(1'b0, dly, qv, r, dv, tv);
    endtask

    task automatic expect_s(input int dly, input int qv, input logic r, input logic dv, input logic tv);
        push_exp(1'b1, dly, qv, r, dv, tv);
    endtask

    // mask bits: {pause, minus, add}; a set bit holds that button low for two clocks
    task automatic press(input logic [2:0] m_mask, input logic [2:0] s_mask);
        {pause_n_m, minus_n_m, add_n_m} = ~m_mask;
        {pause_n_s, minus_n_s, add_n_s} = ~s_mask;
        tick(2);
        {pause_n_m, minus_n_m, add_n_m} = 3'b111;
        {pause_n_s, minus_n_s, add_n_s} = 3'b111;
        tick(2);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [10:0] act;
        mon_i = 0;
        while (mon_i < exp_q.size()) begin
            if (exp_q[mon_i].cyc == cyc) begin
                act = exp_q[mon_i].dut ? {q_s, running_s, dir_up_s, tc_s}
                                       : {q_m, running_m, dir_up_m, tc_m};
                n_checks++;
                if (act !== exp_q[mon_i].val) begin
                    n_fail++;
                    $display("FAIL chk_%s cyc=%0d: got q=%0d run=%b dir=%b tc=%b, expected q=%0d run=%b dir=%b tc=%b",
                             exp_q[mon_i].dut ? "sat" : "wrap", cyc,
                             act[10:3], act[2], act[1], act[0],
                             exp_q[mon_i].val[10:3], exp_q[mon_i].val[2],
                             exp_q[mon_i].val[1], exp_q[mon_i].val[0]);
                end
                exp_q.delete(mon_i);
            end else if (exp_q[mon_i].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL chk_missed cyc=%0d: got no sample, expected one at cyc=%0d",
                         cyc, exp_q[mon_i].cyc);
                exp_q.delete(mon_i);
            end else begin
                mon_i++;
            end
        end
    end

    // Stimulus
    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        {pause_n_m, minus_n_m, add_n_m} = 3'b111;
        {pause_n_s, minus_n_s, add_n_s} = 3'b111;
        load_m = 1'b0;
        load_s = 1'b0;
        d_m    = '0;
        d_s    = '0;
        tick(2);

        // reset state
        expect_m(0, 0, 1, 1, 0);
        expect_s(0, 0, 1, 1, 0);

        // free run: one step every 4 clocks, wrap 9->0 with tc; saturating copy clamps at 9
        reset = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            expect_m(4 * k - 1, k - 1, 1, 1, 0);
            expect_m(4 * k, k, 1, 1, 0);
        end
        expect_m(39, 9, 1, 1, 0);
        expect_m(40, 0, 1, 1, 1);
        expect_m(41, 0, 1, 1, 0);
        expect_s(40, 9, 1, 1, 0);
        tick(41);

        // pause held 3 clocks: HOLD exactly 3 edges after first sample, pending step dropped
        pause_n_m = 1'b0;
        expect_m(2, 0, 1, 1, 0);
        expect_m(3, 0, 0, 1, 0);
        tick(3);
        pause_n_m = 1'b1;

        // HOLD: three add presses, then minus presses down through a wrap
        expect_m(2, 0, 0, 1, 0);
        expect_m(3, 1, 0, 1, 0);
        expect_m(7, 2, 0, 1, 0);
        expect_m(11, 3, 0, 1, 0);
        for (int k = 0; k < 3; k++) press(3'b001, 3'b000);
        expect_m(3, 2, 0, 1, 0);
        expect_m(7, 1, 0, 1, 0);
        expect_m(11, 0, 0, 1, 0);
        expect_m(15, 9, 0, 1, 1);
        expect_m(16, 9, 0, 1, 0);
        for (int k = 0; k < 4; k++) press(3'b010, 3'b000);

        // HOLD at 4: add+minus together is no change
        load_m = 1'b1;
        d_m    = 8'd4;
        expect_m(1, 4, 0, 1, 0);
        tick(1);
        load_m = 1'b0;
        expect_m(3, 4, 0, 1, 0);
        expect_m(4, 4, 0, 1, 0);
        press(3'b011, 3'b000);

        // pause+minus together: back to RUN, minus ignored
        expect_m(2, 4, 0, 1, 0);
        expect_m(3, 4, 1, 1, 0);
        expect_m(4, 4, 1, 1, 0);
        press(3'b110, 3'b000);

        // RUN: step after 4 clocks, then minus press flips direction without stepping
        tick(1);
        expect_m(2, 5, 1, 1, 0);
        expect_m(3, 5, 1, 0, 0);
        press(3'b010, 3'b000);

        // load clamps 200 to 9 and clears the prescaler
        load_m = 1'b1;
        d_m    = 8'd200;
        expect_m(1, 9, 1, 0, 0);
        expect_m(2, 9, 1, 0, 0);
        tick(1);
        load_m = 1'b0;
        tick(2);

        // load 5 in RUN: next step exactly 4 clocks later
        load_m = 1'b1;
        d_m    = 8'd5;
        expect_m(1, 5, 1, 0, 0);
        expect_m(4, 5, 1, 0, 0);
        expect_m(5, 4, 1, 0, 0);
        tick(1);
        load_m = 1'b0;
        tick(4);

        // saturating instance: HOLD, add at 9 and minus at 0 both clamp without tc
        expect_s(2, 9, 1, 1, 0);
        expect_s(3, 9, 0, 1, 0);
        press(3'b000, 3'b100);
        expect_s(3, 9, 0, 1, 0);
        expect_s(4, 9, 0, 1, 0);
        press(3'b000, 3'b001);
        load_s = 1'b1;
        d_s    = 8'd0;
        expect_s(1, 0, 0, 1, 0);
        tick(1);
        load_s = 1'b0;
        expect_s(3, 0, 0, 1, 0);
        expect_s(4, 0, 0, 1, 0);
        press(3'b000, 3'b010);

        // wrapping instance kept counting down meanwhile: 0 -> 9 wrap raises tc
        expect_m(3, 0, 1, 0, 0);
        expect_m(7, 9, 1, 0, 1);
        expect_m(8, 9, 1, 0, 0);
        expect_m(15, 7, 1, 0, 0);
        tick(15);
        tick(1);

        // async reset between edges; pause and add held low across release count once
        reset     = 1'b0;
        pause_n_m = 1'b0;
        add_n_m   = 1'b0;
        expect_m(0, 0, 1, 1, 0);
        tick(2);
        reset = 1'b1;
        expect_m(2, 0, 1, 1, 0);
        expect_m(3, 0, 0, 1, 0);
        expect_m(7, 0, 0, 1, 0);
        expect_m(13, 0, 0, 1, 0);
        tick(13);
        pause_n_m = 1'b1;
        add_n_m   = 1'b1;
        tick(3);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick(1);
        while (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL chk_pending: got no sample, expected one at cyc=%0d", exp_q[0].cyc);
            void'(exp_q.pop_front());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
